// File: rtl/irq_capture8b.sv
// rtl/irq_capture8b.sv - synchronizing edge-capture front end for an 8-bit priority encoder
module irq_capture8b #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic       mask_wr,
  input  logic [7:0] mask_in,
  input  logic       ack,
  input  logic [7:0] ack_onehot,
  input  logic       lost_clr,
  output logic [7:0] data_out,
  output logic       any_pending,
  output logic [7:0] lost
);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] hist_q;
  logic [7:0] pending_q;
  logic [7:0] lost_q;
  logic [7:0] mask_q;

  logic [7:0] irq_edge;
  logic [7:0] ack_clr;
  logic [7:0] pending_d;
  logic [7:0] lost_d;

  assign irq_edge  = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign ack_clr   = ack ? ack_onehot : 8'h00;
  // A fresh edge overrides a same-cycle ack, so it is OR-ed in after the clear.
  assign pending_d = (pending_q & ~ack_clr) | irq_edge;
  assign lost_d    = (lost_clr ? 8'h00 : lost_q) | (irq_edge & pending_q & ~ack_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      hist_q    <= 8'h00;
      pending_q <= 8'h00;
      lost_q    <= 8'h00;
      mask_q    <= 8'hFF;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_in};
      hist_q    <= sync_q[SYNC_STAGES-1];
      pending_q <= pending_d;
      lost_q    <= lost_d;
      if (mask_wr) begin
        mask_q <= mask_in;
      end
    end
  end

  // Outputs come from registers only; nothing combinational from irq_in, ack or mask_in.
  assign data_out    = pending_q & mask_q;
  assign any_pending = |data_out;
  assign lost        = lost_q;

endmodule

// File: tb/tb_irq_capture8b.sv
// tb/tb_irq_capture8b.sv - table-driven scoreboard bench for irq_capture8b
module tb_irq_capture8b;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_in;
  logic       ack;
  logic [7:0] ack_onehot;
  logic       lost_clr;
  logic [7:0] data_out;
  logic       any_pending;
  logic [7:0] lost;

  irq_capture8b #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask_wr(mask_wr), .mask_in(mask_in),
    .ack(ack), .ack_onehot(ack_onehot), .lost_clr(lost_clr),
    .data_out(data_out), .any_pending(any_pending), .lost(lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irq;
    logic       mwr;
    logic [7:0] min;
    logic       ak;
    logic [7:0] aoh;
    logic       lclr;
    logic [7:0] exp_data;
    logic [7:0] exp_lost;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] lost;
    int         row;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks;
  int   failures;

  task automatic check8(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] irq, input logic mwr, input logic [7:0] min, input logic ak,
                     input logic [7:0] aoh, input logic lclr, input logic [7:0] ed, input logic [7:0] el);
    vec_t v;
    v.irq = irq; v.mwr = mwr; v.min = min; v.ak = ak; v.aoh = aoh; v.lclr = lclr;
    v.exp_data = ed; v.exp_lost = el;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [7:0] irq, input logic mwr, input logic [7:0] min, input logic ak,
                       input logic [7:0] aoh, input logic lclr);
    irq_in = irq; mask_wr = mwr; mask_in = min; ack = ak; ack_onehot = aoh; lost_clr = lclr;
  endtask

  task automatic idle_cycle(input logic [7:0] irq);
    drive(irq, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    //        irq  mwr min  ack aoh  clr  data lost
    add(8'h05, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    add(8'h05, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    add(8'h05, 0, 8'h00, 0, 8'h00, 0, 8'h05, 8'h00);
    add(8'h05, 0, 8'h00, 0, 8'h04, 0, 8'h05, 8'h00);
    add(8'h05, 0, 8'h00, 1, 8'h04, 0, 8'h01, 8'h00);
    add(8'h05, 0, 8'h00, 0, 8'h00, 0, 8'h01, 8'h00);
    add(8'h05, 0, 8'h00, 1, 8'hFF, 0, 8'h00, 8'h00);
    add(8'h05, 1, 8'hFE, 0, 8'h00, 0, 8'h00, 8'h00);
    add(8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    add(8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    add(8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    add(8'h01, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    add(8'h01, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    add(8'h01, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    add(8'h01, 1, 8'hFF, 0, 8'h00, 0, 8'h01, 8'h00);
    add(8'h01, 0, 8'h00, 1, 8'h01, 0, 8'h00, 8'h00);
    add(8'h09, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    add(8'h09, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    add(8'h09, 0, 8'h00, 0, 8'h00, 0, 8'h08, 8'h00);
    add(8'h01, 0, 8'h00, 0, 8'h00, 0, 8'h08, 8'h00);
    add(8'h09, 0, 8'h00, 0, 8'h00, 0, 8'h08, 8'h00);
    add(8'h09, 0, 8'h00, 0, 8'h00, 0, 8'h08, 8'h00);
    add(8'h09, 0, 8'h00, 0, 8'h00, 0, 8'h08, 8'h08);
    add(8'h09, 0, 8'h00, 0, 8'h00, 1, 8'h08, 8'h00);
    add(8'h01, 0, 8'h00, 0, 8'h00, 0, 8'h08, 8'h00);
    add(8'h09, 0, 8'h00, 0, 8'h00, 0, 8'h08, 8'h00);
    add(8'h09, 0, 8'h00, 0, 8'h00, 0, 8'h08, 8'h00);
    add(8'h09, 0, 8'h00, 0, 8'h00, 1, 8'h08, 8'h08);
    add(8'h09, 0, 8'h00, 1, 8'h08, 0, 8'h00, 8'h08);
    add(8'h09, 0, 8'h00, 0, 8'h00, 1, 8'h00, 8'h00);
    add(8'h41, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    add(8'h41, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    add(8'h41, 0, 8'h00, 1, 8'h40, 0, 8'h40, 8'h00);
    add(8'h01, 0, 8'h00, 0, 8'h00, 0, 8'h40, 8'h00);
    add(8'h41, 0, 8'h00, 0, 8'h00, 0, 8'h40, 8'h00);
    add(8'h41, 0, 8'h00, 0, 8'h00, 0, 8'h40, 8'h00);
    add(8'h41, 0, 8'h00, 1, 8'h40, 0, 8'h40, 8'h00);
    add(8'h41, 0, 8'h00, 1, 8'h40, 0, 8'h00, 8'h00);

    #2;
    check8("reset_data_out", -1, data_out, 8'h00);
    check8("reset_any_pending", -1, {7'b0, any_pending}, 8'h00);
    check8("reset_lost", -1, lost, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].irq, tbl[i].mwr, tbl[i].min, tbl[i].ak, tbl[i].aoh, tbl[i].lclr);
      e.data = tbl[i].exp_data;
      e.lost = tbl[i].exp_lost;
      e.row  = i;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check8("data_out", e.row, data_out, e.data);
      check8("any_pending", e.row, {7'b0, any_pending}, {7'b0, |e.data});
      check8("lost", e.row, lost, e.lost);
    end

    // Build pending=FF, lost=10, mask=0F, then reset asynchronously.
    for (int i = 0; i < 3; i++) idle_cycle(8'h00);
    for (int i = 0; i < 3; i++) idle_cycle(8'hFF);
    idle_cycle(8'hEF);
    for (int i = 0; i < 3; i++) idle_cycle(8'hFF);
    drive(8'hFF, 1'b1, 8'h0F, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    drive(8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check8("pre_reset_data_out", -2, data_out, 8'h0F);
    check8("pre_reset_lost", -2, lost, 8'h10);

    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    irq_in = 8'h80;
    #1;
    check8("async_reset_data_out", -3, data_out, 8'h00);
    check8("async_reset_any_pending", -3, {7'b0, any_pending}, 8'h00);
    check8("async_reset_lost", -3, lost, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check8("release_edge1", -4, data_out, 8'h00);
    @(negedge clk);
    check8("release_edge2", -4, data_out, 8'h00);
    @(negedge clk);
    check8("release_edge3", -4, data_out, 8'h80);
    check8("release_lost", -4, lost, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
